// File: rtl/serial_twos_decoder.sv
// Receive side of the bit-serial two's-complement link: re-negates an LSB-first frame
// on the fly, re-emits it serially and assembles it into a parallel word.
module serial_twos_decoder #(
  parameter int WIDTH = 8
) (
  input  logic             t_clk,
  input  logic             r_n,
  input  logic             i,
  input  logic             i_vld,
  input  logic             sof,
  output logic             y,
  output logic             y_vld,
  output logic [WIDTH-1:0] y_par,
  output logic             p_vld,
  output logic             ovf,
  output logic             err,
  output logic             busy
);

  // state | meaning
  // IDLE  | waiting for a valid sof; bits without sof are dropped
  // RECV  | mid-frame, bits 1..WIDTH-1 still to arrive
  typedef enum logic {IDLE = 1'b0, RECV = 1'b1} state_t;

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             seen_q, seen_d;
  logic [WIDTH-2:0] sh_q, sh_d;
  logic             y_q, y_d;
  logic             y_vld_q, y_vld_d;
  logic [WIDTH-1:0] y_par_q, y_par_d;
  logic             p_vld_q, p_vld_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;

  logic             start;
  logic             accept;
  logic             seen_eff;
  logic             o_bit;
  logic [CW-1:0]    cnt_eff;
  logic [WIDTH-2:0] sh_base;
  logic [WIDTH-1:0] word;

  always_comb begin
    // A valid sof always opens a new frame, whether idle or aborting one in progress.
    start    = i_vld && sof;
    accept   = i_vld && (state_q == RECV || sof);
    seen_eff = start ? 1'b0 : seen_q;
    cnt_eff  = start ? '0 : cnt_q;
    sh_base  = start ? '0 : sh_q;
    o_bit    = seen_eff ? ~i : i;
    word     = {o_bit, sh_base};

    state_d = state_q;
    cnt_d   = cnt_q;
    seen_d  = seen_q;
    sh_d    = sh_q;
    y_d     = y_q;
    y_vld_d = 1'b0;
    y_par_d = y_par_q;
    p_vld_d = 1'b0;
    ovf_d   = 1'b0;
    err_d   = start && (state_q == RECV);

    if (accept) begin
      y_d     = o_bit;
      y_vld_d = 1'b1;
      seen_d  = seen_eff | i;
      sh_d    = word[WIDTH-1:1];
      if (cnt_eff == LAST) begin
        cnt_d   = '0;
        state_d = IDLE;
        y_par_d = word;
        p_vld_d = 1'b1;
        ovf_d   = (word == MIN_NEG);
      end else begin
        cnt_d   = cnt_eff + CW'(1);
        state_d = RECV;
      end
    end
  end

  always_ff @(posedge t_clk or negedge r_n) begin
    if (!r_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      seen_q  <= 1'b0;
      sh_q    <= '0;
      y_q     <= 1'b0;
      y_vld_q <= 1'b0;
      y_par_q <= '0;
      p_vld_q <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      seen_q  <= seen_d;
      sh_q    <= sh_d;
      y_q     <= y_d;
      y_vld_q <= y_vld_d;
      y_par_q <= y_par_d;
      p_vld_q <= p_vld_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  assign y     = y_q;
  assign y_vld = y_vld_q;
  assign y_par = y_par_q;
  assign p_vld = p_vld_q;
  assign ovf   = ovf_q;
  assign err   = err_q;
  assign busy  = (state_q == RECV);

endmodule
